// File: rtl/lu_rmw_pipeline_pkg.sv
// Shared types and arithmetic for the read-modify-write pipeline.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package lu_rmw_pkg;

    // Widest operand and address supported. Stage records are sized to these.
    localparam int MAX_W  = 64;
    localparam int MAX_AW = 32;

    typedef enum logic [1:0] {
        OP_INC = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_WR  = 2'b11
    } op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] addr;
        op_e               op;
        logic [MAX_W-1:0]  operand;
    } stage_t;

    // Applies op to old_v on a dw-bit word.
    // Carry and borrow are taken from bit dw of a dw+1 bit intermediate.
    // With sat set, overflow clamps to all-ones and SUB underflow clamps to 0.
    function automatic logic [MAX_W-1:0] rmw_calc(
        input op_e              op,
        input logic [MAX_W-1:0] old_v,
        input logic [MAX_W-1:0] opnd,
        input int               dw,
        input logic             sat
    );
        logic [MAX_W:0] one_w;
        logic [MAX_W:0] mask_w;
        logic [MAX_W:0] a;
        logic [MAX_W:0] b;
        logic [MAX_W:0] wide;
        logic           carry;
        one_w  = {{MAX_W{1'b0}}, 1'b1};
        mask_w = (one_w << dw) - one_w;
        a      = {1'b0, old_v} & mask_w;
        b      = {1'b0, opnd} & mask_w;
        case (op)
            OP_INC:  wide = a + one_w;
            OP_ADD:  wide = a + b;
            OP_SUB:  wide = a - b;
            default: wide = b;
        endcase
        // A borrow fills every bit above dw, so testing bit dw covers both directions.
        carry = ((wide >> dw) & one_w) != '0;
        if (sat && carry) begin
            wide = (op == OP_SUB) ? '0 : mask_w;
        end
        return wide[MAX_W-1:0] & mask_w[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/lu_rmw_pipeline_if.sv
// Request and result streams of the read-modify-write pipeline.
// Latency: n/a (wiring only).
// Backpressure: in_ready is driven by the pipeline; the result side has no ready.
interface lu_rmw_pipeline_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_operand;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              init_done;

    modport master (
        output in_valid, in_addr, in_op, in_operand,
        input  in_ready, out_valid, out_addr, out_data, init_done
    );

    modport slave (
        input  in_valid, in_addr, in_op, in_operand,
        output in_ready, out_valid, out_addr, out_data, init_done
    );
endinterface

// File: rtl/lu_rmw_pipeline_mem2p.sv
// Generic dual-port memory: port 0 read-only with a registered address, port 1 write-only.
// Latency: read data follows the address one clock later and shows same-edge writes.
// Backpressure: none.
module lu_mem2p #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] raddr_q;

    // Register the read address and commit any write.
    always_ff @(posedge clk) begin
        raddr_q <= raddr_i;
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_q];
endmodule

// File: rtl/lu_rmw_pipeline.sv
// Read-modify-write pipeline (INC/ADD/SUB/WR) over an internal memory, with a clear sweep after reset.
// Latency: accept at edge k -> out_valid after edge k+3; the memory write commits at edge k+4.
// Backpressure: in_ready is low only during the clear sweep; results cannot be stalled.
module lu_rmw_pipeline #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int SAT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    lu_rmw_pipeline_if.slave bus
);
    import lu_rmw_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;

    stage_t            s0_d, s0_q, s1_q, s2_q;
    logic              s3_vld_q;
    logic [MAX_AW-1:0] s3_addr_q;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] old_q, old_sel, old_use, rd_dat;

    // Write-back copy of the last committed result, and one more cycle of history after it.
    logic              wb_vld_q, byp_vld_q;
    logic [MAX_AW-1:0] wb_addr_q, byp_addr_q;
    logic [DATA_W-1:0] wb_dat_q, byp_dat_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdat;
    logic              run, accept;

    assign run            = (state_q == ST_RUN) && !rst;
    assign accept         = bus.in_valid && run;
    assign bus.in_ready   = run;
    assign bus.init_done  = run;
    assign bus.out_valid  = s3_vld_q && !rst;
    assign bus.out_addr   = rst ? '0 : ADDR_W'(s3_addr_q);
    assign bus.out_data   = rst ? '0 : res_q;

    // FSM state and sweep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Next state and write-port ownership: the sweep in INIT, the S3 result in RUN.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        mem_we    = 1'b0;
        mem_waddr = ADDR_W'(s3_addr_q);
        mem_wdat  = res_q;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdat  = '0;
                sweep_d   = sweep_q + 1'b1;
                if (sweep_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                mem_we = s3_vld_q;
            end
        endcase
        // A request caught by reset must never reach memory.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    // Capture an accepted request into S0.
    always_comb begin
        s0_d = '0;
        if (accept) begin
            s0_d.valid   = 1'b1;
            s0_d.addr    = MAX_AW'(bus.in_addr);
            s0_d.op      = op_e'(bus.in_op);
            s0_d.operand = MAX_W'(bus.in_operand);
        end
    end

    // S2 old-value select for the request in S1.
    // Later assignments win, so the youngest older match takes priority.
    // A distance-1 request is still in S2 and is resolved in old_use.
    always_comb begin
        old_sel = rd_dat;
        if (byp_vld_q && (byp_addr_q == s1_q.addr)) old_sel = byp_dat_q;
        if (wb_vld_q && (wb_addr_q == s1_q.addr))   old_sel = wb_dat_q;
        if (s3_vld_q && (s3_addr_q == s1_q.addr))   old_sel = res_q;
    end

    // S3 compute: the S3 result register overrides when the request just ahead hit the same word.
    always_comb begin
        old_use = (s3_vld_q && (s3_addr_q == s2_q.addr)) ? res_q : old_q;
        res_d   = DATA_W'(rmw_calc(s2_q.op, MAX_W'(old_use), s2_q.operand, DATA_W, SAT != 0));
    end

    // Advance the stages. Reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q       <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            old_q      <= '0;
            s3_vld_q   <= 1'b0;
            s3_addr_q  <= '0;
            res_q      <= '0;
            wb_vld_q   <= 1'b0;
            wb_addr_q  <= '0;
            wb_dat_q   <= '0;
            byp_vld_q  <= 1'b0;
            byp_addr_q <= '0;
            byp_dat_q  <= '0;
        end else begin
            s0_q       <= s0_d;
            s1_q       <= s0_q;
            s2_q       <= s1_q;
            old_q      <= old_sel;
            s3_vld_q   <= s2_q.valid;
            s3_addr_q  <= s2_q.addr;
            res_q      <= res_d;
            wb_vld_q   <= s3_vld_q;
            wb_addr_q  <= s3_addr_q;
            wb_dat_q   <= res_q;
            byp_vld_q  <= wb_vld_q;
            byp_addr_q <= wb_addr_q;
            byp_dat_q  <= wb_dat_q;
        end
    end

    lu_mem2p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .raddr_i (ADDR_W'(s0_q.addr)),
        .rdata_o (rd_dat),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdat)
    );
endmodule

// File: tb/tb_lu_rmw_pipeline.sv
// Directed bench for lu_rmw_pipeline: one wrapping and one saturating instance fed the same requests.
// Outputs are collected on the falling edge and compared against hand-computed values.
module tb_lu_rmw_pipeline;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam logic [1:0] INC = 2'b00;
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] SUB = 2'b10;
    localparam logic [1:0] WR  = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lu_rmw_pipeline_if #(.DATA_W(DW), .ADDR_W(AW)) bw ();
    lu_rmw_pipeline_if #(.DATA_W(DW), .ADDR_W(AW)) bs ();

    lu_rmw_pipeline #(.DATA_W(DW), .ADDR_W(AW), .SAT(0)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bw.slave)
    );

    lu_rmw_pipeline #(.DATA_W(DW), .ADDR_W(AW), .SAT(1)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bs.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int last_acc;
    int last_cyc_w;

    logic [31:0] qd_w[$];
    logic [31:0] qa_w[$];
    int          qc_w[$];
    logic [31:0] qd_s[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Result collector.
    always @(negedge clk) begin
        if (bw.out_valid === 1'b1) begin
            qd_w.push_back(32'(bw.out_data));
            qa_w.push_back(32'(bw.out_addr));
            qc_w.push_back(cyc);
        end
        if (bs.out_valid === 1'b1) begin
            qd_s.push_back(32'(bs.out_data));
        end
    end

    task automatic req(input logic v, input logic [7:0] a, input logic [1:0] op, input logic [15:0] d);
        bw.in_valid = v; bw.in_addr = a; bw.in_op = op; bw.in_operand = d;
        bs.in_valid = v; bs.in_addr = a; bs.in_op = op; bs.in_operand = d;
        @(posedge clk);
        #1;
        last_acc = cyc;
        bw.in_valid = 1'b0;
        bs.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_out(input string tag, input logic [31:0] ea, input logic [31:0] ew, input logic [31:0] es);
        logic [31:0] gw, ga, gs;
        gw = 'x; ga = 'x; gs = 'x;
        if (qd_w.size() > 0) begin
            gw = qd_w.pop_front();
            ga = qa_w.pop_front();
            last_cyc_w = qc_w.pop_front();
        end
        if (qd_s.size() > 0) gs = qd_s.pop_front();
        chk({tag, "_addr"}, ga, ea);
        chk({tag, "_wrap"}, gw, ew);
        chk({tag, "_sat"}, gs, es);
    endtask

    // Counts cycles with in_ready low after rst is released, bounded.
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bw.in_ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_len"}, 32'(n), 256);
        chk({tag, "_done"}, 32'(bw.init_done), 1);
        chk({tag, "_rdy_s"}, 32'(bs.in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        prev = 0;
        bw.in_valid = 1'b0; bw.in_addr = '0; bw.in_op = '0; bw.in_operand = '0;
        bs.in_valid = 1'b0; bs.in_addr = '0; bs.in_op = '0; bs.in_operand = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bw.in_ready), 0);
        chk("rst_out_valid", 32'(bw.out_valid), 0);
        chk("rst_out_addr", 32'(bw.out_addr), 0);
        chk("rst_out_data", 32'(bw.out_data), 0);
        chk("rst_init_done", 32'(bw.init_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init("init1");
        chk("init_no_out", 32'(qd_w.size()), 0);

        // First request after the sweep, with latency.
        req(1'b1, 8'h05, INC, 16'h0);
        prev = last_acc;
        idle(6);
        exp_out("inc5", 8'h05, 1, 1);
        chk("inc5_latency", 32'(last_cyc_w - prev), 3);

        // Back-to-back same address.
        for (int i = 0; i < 4; i++) req(1'b1, 8'h10, INC, 16'h0);
        idle(8);
        for (int i = 0; i < 4; i++) begin
            exp_out($sformatf("b2b%0d", i), 8'h10, 32'(i + 1), 32'(i + 1));
            if (i > 0) chk($sformatf("b2b_gap%0d", i), 32'(last_cyc_w - prev), 1);
            prev = last_cyc_w;
        end
        req(1'b1, 8'h10, INC, 16'h0);
        idle(8);
        exp_out("b2b_readback", 8'h10, 5, 5);

        // Spaced hazards: distances 2, 3, 4, 5.
        req(1'b1, 8'h03, INC, 16'h0); idle(1);
        req(1'b1, 8'h03, INC, 16'h0); idle(2);
        req(1'b1, 8'h03, INC, 16'h0); idle(3);
        req(1'b1, 8'h03, INC, 16'h0); idle(4);
        req(1'b1, 8'h03, INC, 16'h0);
        idle(8);
        for (int i = 0; i < 5; i++) exp_out($sformatf("spaced%0d", i), 8'h03, 32'(i + 1), 32'(i + 1));

        // Interleaved addresses, distance-2 forwarding.
        req(1'b1, 8'h20, INC, 16'h0);
        req(1'b1, 8'h21, INC, 16'h0);
        req(1'b1, 8'h20, INC, 16'h0);
        req(1'b1, 8'h21, INC, 16'h0);
        idle(8);
        exp_out("ilv0", 8'h20, 1, 1);
        exp_out("ilv1", 8'h21, 1, 1);
        exp_out("ilv2", 8'h20, 2, 2);
        exp_out("ilv3", 8'h21, 2, 2);

        // Mixed operations back-to-back.
        req(1'b1, 8'h07, WR, 16'd100);
        req(1'b1, 8'h07, ADD, 16'd25);
        req(1'b1, 8'h07, SUB, 16'd30);
        idle(8);
        exp_out("mix_wr", 8'h07, 100, 100);
        exp_out("mix_add", 8'h07, 125, 125);
        exp_out("mix_sub", 8'h07, 95, 95);

        // in_valid low: request fields are ignored.
        req(1'b0, 8'h07, WR, 16'd999);
        idle(8);
        chk("novalid_no_out", 32'(qd_w.size()), 0);
        req(1'b1, 8'h07, INC, 16'h0);
        idle(8);
        exp_out("novalid_readback", 8'h07, 96, 96);

        // Overflow: wrap versus clamp.
        req(1'b1, 8'h02, WR, 16'hFFFE);
        req(1'b1, 8'h02, INC, 16'h0);
        req(1'b1, 8'h02, INC, 16'h0);
        idle(8);
        exp_out("ovf_wr", 8'h02, 32'hFFFE, 32'hFFFE);
        exp_out("ovf_inc1", 8'h02, 32'hFFFF, 32'hFFFF);
        exp_out("ovf_inc2", 8'h02, 32'h0000, 32'hFFFF);

        // Underflow on SUB.
        req(1'b1, 8'h02, WR, 16'd3);
        req(1'b1, 8'h02, SUB, 16'd5);
        idle(8);
        exp_out("unf_wr", 8'h02, 3, 3);
        exp_out("unf_sub", 8'h02, 32'hFFFE, 32'h0000);

        // ADD overflow.
        req(1'b1, 8'h04, WR, 16'hFFF0);
        req(1'b1, 8'h04, ADD, 16'h0020);
        idle(8);
        exp_out("addovf_wr", 8'h04, 32'hFFF0, 32'hFFF0);
        exp_out("addovf_add", 8'h04, 32'h0010, 32'hFFFF);

        // Reset with requests in flight.
        req(1'b1, 8'h09, WR, 16'd50);
        idle(8);
        exp_out("pre_rst_wr", 8'h09, 50, 50);
        req(1'b1, 8'h09, INC, 16'h0);
        req(1'b1, 8'h09, INC, 16'h0);
        req(1'b1, 8'h09, INC, 16'h0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        wait_init("init2");
        chk("rst_dropped_w", 32'(qd_w.size()), 0);
        chk("rst_dropped_s", 32'(qd_s.size()), 0);
        req(1'b1, 8'h09, INC, 16'h0);
        req(1'b1, 8'h07, INC, 16'h0);
        idle(8);
        exp_out("post_rst9", 8'h09, 1, 1);
        exp_out("post_rst7", 8'h07, 1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lu_rmw_pipeline.md
Name: lu_rmw_pipeline

Overview:
- Parametrised read-modify-write pipeline over an internal 2^ADDR_W x DATA_W dual-port synchronous memory. Successor to the fixed 8-bit-address, increment-only locked-update processor.
- Adds a valid/ready handshake, a selectable operation per request, and wrap or saturate arithmetic.
- Adds a post-reset memory-clear state machine and a result output stream.
- Sits between a request source (event/histogram counters, lookup updates) and a downstream result consumer.

Parameters:
- DATA_W, 16: memory word and operand width.
- ADDR_W, 8: address width; depth is 2^ADDR_W.
- SAT, 0: 0 means arithmetic wraps modulo 2^DATA_W; 1 means it saturates at 0 and at 2^DATA_W-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request; low during INIT.
- in_addr  in  ADDR_W  target word.
- in_op  in  2  operation: 00 INC, 01 ADD, 10 SUB, 11 WR.
- in_operand  in  DATA_W  operand for ADD, SUB and WR; ignored for INC.
- out_valid  out  1  one pulse per accepted request.
- out_addr  out  ADDR_W  address of the completed request.
- out_data  out  DATA_W  new value written to that address.
- init_done  out  1  high once the clear sweep has finished.

Behaviour:
- Reset: on any edge with rst=1, the FSM enters INIT, the sweep counter is 0, and all stage valids are cleared.
  - Outputs during reset: in_ready=0, out_valid=0, out_addr=0, out_data=0, init_done=0.
  - rst asserted mid-operation: all in-flight requests are dropped and never produce out_valid or a memory write.
  - Memory contents are not reset directly; they are cleared only by the sweep.
- FSM INIT: writes 0 to address sweep_cnt through the write port, one address per cycle, then increments sweep_cnt.
  - When sweep_cnt = 2^ADDR_W-1 has been written, the FSM moves to RUN.
  - INIT lasts exactly 2^ADDR_W cycles after rst deasserts.
- FSM RUN: in_ready=1 and init_done=1. RUN is left only via rst.
  - No backpressure from the output side: in_ready stays 1 in RUN, so throughput is 1 request per cycle.
- Acceptance: a request is accepted on an edge where in_valid && in_ready. in_addr, in_op and in_operand are ignored otherwise.
- Pipeline stages:
  - S0: capture the request.
  - S1: issue the memory read (registered address).
  - S2: select the old value (memory read data or forwarded value).
  - S3: compute and register the result.
  - S4: write the result to memory on port 1.
- Latency: a request accepted at edge k gives out_valid=1 in the cycle after edge k+3, with out_addr/out_data from that request. The memory write commits at edge k+4.
- Ordering: results are produced strictly in acceptance order.
- Hazards: each request's old value equals the value left by all previously accepted requests, for any spacing (distance 1, 2, 3, 4 or more), including back-to-back requests to the same address.
  - Forwarding sources: the S3 result register, the S4 write-back register, and a one-cycle post-write bypass register covering the memory read-during-write window.
  - The youngest matching older request wins.
  - Matches are gated by stage valid bits; an invalid stage never forwards.
- Arithmetic (old = forwarded/read value):
  - INC: old + 1.
  - ADD: old + in_operand.
  - SUB: old - in_operand.
  - WR: in_operand.
  - SAT=0: all results are truncated to DATA_W bits.
  - SAT=1: overflow clamps to all-ones, and SUB underflow clamps to 0. Carry/borrow is detected on a DATA_W+1 bit intermediate.
- Memory port 0 is read-only. Port 1 is write-only, shared by the INIT sweep and S4 write-back; both cannot be active at once because no requests are accepted in INIT.

Decomposition:
- Package lu_rmw_pkg: op enum (OP_INC, OP_ADD, OP_SUB, OP_WR), FSM state enum (ST_INIT, ST_RUN), and the stage record typedef (valid, addr, op, operand).
- Package function: the arithmetic op function, parametrised by DATA_W and SAT.
- Sub-module: lu_mem2p, a generic parametrised dual-port synchronous memory with registered read address and no simulation-only dump code.

Test Plan:
- INIT: assert rst for 2 cycles, then release → in_ready=0 for exactly 256 cycles (ADDR_W=8). init_done rises on the following cycle. A first INC to address 5 gives out_data=1.
- Back-to-back hazard: 4 consecutive INC to address 0x10 → out_data sequence 1, 2, 3, 4 on consecutive cycles; a later read-back via INC gives 5.
- Spaced hazards: INC addr 3, 1 idle cycle, INC addr 3, 2 idle cycles, INC addr 3, 3 idle cycles, INC addr 3 → out_data 1, 2, 3, 4.
- Mixed ops: WR 0x7 with 100, then ADD 0x7 with 25, then SUB 0x7 with 30, issued back-to-back → out_data 100, 125, 95.
- Saturation, with SAT=1 and DATA_W=16:
  - WR addr 2 with 0xFFFE, then INC, then INC → 0xFFFF, 0xFFFF.
  - WR addr 2 with 3, then SUB 5 → 0.
  - With SAT=0, the same INC sequence gives 0xFFFF, 0x0000.
- Reset mid-flight: issue 3 INCs to addr 9, then assert rst one cycle later → no out_valid for the dropped requests. After the new INIT, INC addr 9 gives out_data=1.
